// File: rtl/regslv_pkg.sv
// Shared types and the address decode helper for the parametrised register slave.
package regslv_pkg;

  // Hardware-side access mode of one register.
  typedef enum logic [1:0] {
    HW_RO  = 2'd0,
    HW_RW  = 2'd1,
    HW_CLR = 2'd2,
    HW_SET = 2'd3
  } hw_mode_e;

  // Software-side access mode of one register.
  typedef enum logic [1:0] {
    SW_RW   = 2'd0,
    SW_RO   = 2'd1,
    SW_RCLR = 2'd2,
    SW_W1C  = 2'd3
  } sw_mode_e;

  // Bus transaction FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Decode result: hit is clear for misaligned, below-base or out-of-range addresses.
  typedef struct packed {
    logic       hit;
    logic [5:0] idx;
  } addr_dec_t;

  // Converts a byte address to a register index. Stride is 2**shift bytes, which
  // keeps the divide a plain shift; register count is capped at 64.
  function automatic addr_dec_t addr_to_idx(input logic [63:0] addr,
                                            input logic [63:0] base,
                                            input int unsigned shift,
                                            input int unsigned reg_num);
    logic [63:0] off;
    logic [63:0] mask;
    logic [63:0] idx_full;
    addr_dec_t   dec;
    off      = addr - base;
    mask     = (64'd1 << shift) - 64'd1;
    idx_full = off >> shift;
    dec.hit  = (addr >= base) && ((off & mask) == 64'd0) && (idx_full < 64'(reg_num));
    dec.idx  = idx_full[5:0];
    return dec;
  endfunction

endpackage

// File: rtl/regslv_field.sv
// One register: software side effect first, hardware effect layered on top, with
// async and sync reset back to the per-register reset value.
module regslv_field
  import regslv_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter hw_mode_e              HW_MODE    = HW_RO,
  parameter sw_mode_e              SW_MODE    = SW_RW,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync_rst,
  input  logic                  sw_wr,
  input  logic                  sw_rd,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] hw_next,
  input  logic                  hw_pulse,
  output logic [DATA_WIDTH-1:0] value
);

  logic [DATA_WIDTH-1:0] sw_val;
  logic [DATA_WIDTH-1:0] nxt_val;

  // Software access effect on the current value.
  always_comb begin
    sw_val = value;
    case (SW_MODE)
      SW_RW:   if (sw_wr) sw_val = wr_data;
      SW_RCLR: if (sw_rd) sw_val = '0;
      SW_W1C:  if (sw_wr) sw_val = value & ~wr_data;
      default: sw_val = value;
    endcase
  end

  // Hardware effect applied after the software effect so hardware wins a collision.
  always_comb begin
    nxt_val = sw_val;
    case (HW_MODE)
      HW_RW:   if (hw_pulse) nxt_val = hw_next;
      HW_CLR:  nxt_val = sw_val & ~hw_next;
      HW_SET:  nxt_val = sw_val | hw_next;
      default: nxt_val = sw_val;
    endcase
  end

  // Register storage; the soft reset overrides any same-cycle update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= RST_VAL;
    end else if (sync_rst) begin
      value <= RST_VAL;
    end else begin
      value <= nxt_val;
    end
  end

endmodule

// File: rtl/regslv_param_block.sv
// Parametrised register slave on the req_vld/ack_vld native bus: request FSM with
// configurable ack latency, address decode, read mux and REG_NUM register fields.
module regslv_param_block
  import regslv_pkg::*;
#(
  parameter int unsigned                    ADDR_WIDTH = 64,
  parameter int unsigned                    DATA_WIDTH = 32,
  parameter int unsigned                    REG_NUM    = 4,
  parameter logic [ADDR_WIDTH-1:0]          BASE_ADDR  = '0,
  parameter logic [2*REG_NUM-1:0]           HW_MODE    = {REG_NUM{HW_RO}},
  parameter logic [2*REG_NUM-1:0]           SW_MODE    = {REG_NUM{SW_RW}},
  parameter logic [REG_NUM*DATA_WIDTH-1:0]  RST_VAL    = '0,
  parameter int unsigned                    ACK_LAT    = 1
) (
  input  logic                          fsm_clk,
  input  logic                          fsm_rst,
  input  logic                          req_vld,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          ack_vld,
  output logic [DATA_WIDTH-1:0]         rd_data,
  input  logic [REG_NUM*DATA_WIDTH-1:0] hw_next_value,
  input  logic [REG_NUM-1:0]            hw_pulse,
  output logic [REG_NUM*DATA_WIDTH-1:0] hw_curr_value,
  input  logic                          global_sync_reset_in,
  output logic                          global_sync_reset_out
);

  // Handshake: a request is a one-cycle req_vld with wr_en or rd_en, accepted only
  // in IDLE; ack_vld pulses for one cycle exactly ACK_LAT cycles later and rd_data
  // is meaningful only in that cycle. wr_en wins when both qualifiers are set.

  localparam int unsigned SHIFT = $clog2(DATA_WIDTH / 8);

  state_e                  state, state_n;
  logic [3:0]              cnt, cnt_n;
  logic                    load;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic                    lat_wr;
  logic                    lat_rd;
  logic                    in_ack;
  addr_dec_t               dec;
  logic [REG_NUM-1:0]      sw_wr;
  logic [REG_NUM-1:0]      sw_rd;
  logic [DATA_WIDTH-1:0]   rd_sel;

  // Next-state and latency counter control.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (req_vld && (wr_en || rd_en)) begin
          load    = 1'b1;
          cnt_n   = 4'(ACK_LAT - 1);
          state_n = (ACK_LAT == 1) ? ACK : WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = ACK;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, counter, request latches and the soft-reset pass-through.
  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      lat_addr              <= '0;
      lat_data              <= '0;
      lat_wr                <= 1'b0;
      lat_rd                <= 1'b0;
      global_sync_reset_out <= 1'b0;
    end else begin
      global_sync_reset_out <= global_sync_reset_in;
      if (global_sync_reset_in) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
        if (load) begin
          lat_addr <= addr;
          lat_data <= wr_data;
          lat_wr   <= wr_en;
          lat_rd   <= rd_en & ~wr_en;
        end
      end
    end
  end

  assign in_ack = (state == ACK);
  assign dec    = addr_to_idx(64'(lat_addr), 64'(BASE_ADDR), SHIFT, REG_NUM);

  // Per-register access strobes during ACK and the read mux for the decoded index.
  always_comb begin
    sw_wr  = '0;
    sw_rd  = '0;
    rd_sel = '0;
    for (int i = 0; i < int'(REG_NUM); i++) begin
      if (dec.hit && (dec.idx == 6'(i))) begin
        sw_wr[i] = in_ack & lat_wr;
        sw_rd[i] = in_ack & lat_rd;
        rd_sel   = hw_curr_value[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ack_vld = in_ack;
  assign rd_data = (in_ack && lat_rd) ? rd_sel : '0;

  for (genvar g = 0; g < int'(REG_NUM); g++) begin : g_reg
    regslv_field #(
      .DATA_WIDTH (DATA_WIDTH),
      .HW_MODE    (hw_mode_e'(HW_MODE[2*g +: 2])),
      .SW_MODE    (sw_mode_e'(SW_MODE[2*g +: 2])),
      .RST_VAL    (RST_VAL[g*DATA_WIDTH +: DATA_WIDTH])
    ) u_field (
      .clk      (fsm_clk),
      .rst      (fsm_rst),
      .sync_rst (global_sync_reset_in),
      .sw_wr    (sw_wr[g]),
      .sw_rd    (sw_rd[g]),
      .wr_data  (lat_data),
      .hw_next  (hw_next_value[g*DATA_WIDTH +: DATA_WIDTH]),
      .hw_pulse (hw_pulse[g]),
      .value    (hw_curr_value[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: doc/regslv_param_block.md
Name: regslv_param_block

Overview:
- Parametrised register slave that hosts REG_NUM internal registers behind the reg_native_if (req_vld/ack_vld) bus driven by an upstream regmst.
- Each register has a per-register hardware access mode (ro, rw-pulse, hwclr, hwset) and a software access mode (rw, ro, read-clear, write-1-clear).
- The block adds a configurable read/write ack latency and a registered global sync-reset pass-through.
- It replaces fixed-count, fixed-mode generated slaves.

Parameters:
- ADDR_WIDTH, 64, bus address width.
- DATA_WIDTH, 32, register and bus data width.
- REG_NUM, 4, number of registers. Range 1..64.
- BASE_ADDR, 0, address of register 0. Registers sit at stride DATA_WIDTH/8 bytes.
- HW_MODE, {REG_NUM{HW_RO}}, packed 2 bits per register: 0 HW_RO, 1 HW_RW, 2 HW_CLR, 3 HW_SET.
- SW_MODE, {REG_NUM{SW_RW}}, packed 2 bits per register: 0 SW_RW, 1 SW_RO, 2 SW_RCLR, 3 SW_W1C.
- RST_VAL, 0, packed DATA_WIDTH bits per register, reset value.
- ACK_LAT, 1, cycles from accepted request to ack_vld. Range 1..15.

Ports:
- fsm_clk  in  1  single clock.
- fsm_rst  in  1  asynchronous, active-high reset.
- req_vld  in  1  request strobe, one cycle.
- wr_en  in  1  write qualifier, sampled with req_vld.
- rd_en  in  1  read qualifier, sampled with req_vld.
- addr  in  ADDR_WIDTH  byte address.
- wr_data  in  DATA_WIDTH  write data.
- ack_vld  out  1  one-cycle completion strobe.
- rd_data  out  DATA_WIDTH  read data, valid only with ack_vld, else 0.
- hw_next_value  in  REG_NUM*DATA_WIDTH  hw load value (HW_RW) or bit mask (HW_CLR/HW_SET).
- hw_pulse  in  REG_NUM  hw load enable, used by HW_RW only.
- hw_curr_value  out  REG_NUM*DATA_WIDTH  current register contents.
- global_sync_reset_in  in  1  synchronous soft reset.
- global_sync_reset_out  out  1  global_sync_reset_in delayed one cycle.

Behaviour:
- Reset (fsm_rst=1, async): registers take RST_VAL; ack_vld=0; rd_data=0; global_sync_reset_out=0; FSM goes to IDLE; latency counter = 0.
- FSM states:
  - IDLE: req_vld & (wr_en|rd_en) latches addr/wr_data/op and loads the counter with ACK_LAT-1. If ACK_LAT=1, go to ACK; else go to WAIT.
  - WAIT: decrement the counter; go to ACK when it reaches 0.
  - ACK: drive ack_vld=1 for exactly one cycle, then return to IDLE.
- Latency: ack_vld rises exactly ACK_LAT cycles after the req_vld cycle.
- req_vld outside IDLE is ignored. Upstream guarantees one outstanding request.
- req_vld with wr_en=rd_en=0 is ignored. wr_en=rd_en=1 is treated as a write.
- Register update happens at the ACK-state edge. Write effects are visible in hw_curr_value the cycle after ack_vld.
  - Read data is sampled and the read side-effect applied in the same cycle.
  - rd_data holds the pre-clear value.
- Software modes:
  - SW_RW: write loads the value.
  - SW_RO: write ignored.
  - SW_RCLR: read returns the value, then the register becomes 0; write ignored.
  - SW_W1C: write clears the bits set in wr_data.
- Hardware modes:
  - HW_RO: no hw update.
  - HW_RW: hw_pulse loads hw_next_value.
  - HW_CLR: every cycle, bits set in hw_next_value are cleared, with no pulse needed.
  - HW_SET: every cycle, bits set in hw_next_value are set, with no pulse needed.
- Same-cycle sw and hw update: the sw effect is computed first and the hw effect is applied on top, so hw wins.
  - Example: RCLR read plus HW_SET mask 0x1 leaves bit0=1.
- Address decode:
  - Index = (addr-BASE_ADDR)/(DATA_WIDTH/8).
  - Misaligned addresses, addresses below BASE_ADDR, and index ≥ REG_NUM still get acked.
  - For such addresses, rd_data=0 and no register changes.
- global_sync_reset_in=1 at an edge: all registers go to RST_VAL, the FSM goes to IDLE, and the counter clears.
  - An in-flight request is dropped with no ack.
  - A req_vld in the same cycle is ignored.
- Async reset mid-transaction: the ack is lost. Upstream timeout handles this.

Decomposition:
- Package regslv_pkg holds:
  - enums hw_mode_e and sw_mode_e (2 bits each);
  - fsm state enum {IDLE, WAIT, ACK};
  - function addr_to_idx.
- Sub-module regslv_field (one register: sw/hw update and reset), instantiated REG_NUM times via generate.
- The FSM, decode and read mux live in the top module.

Test Plan:
- Reset, then check every register through hw_curr_value: REG_NUM=4, RST_VAL={0,0xA5A5A5A5,0xFFFFFFFF,0} -> hw_curr_value matches exactly; ack_vld=0.
- SW_RW/HW_RW reg1, write 0x12345678 -> ack_vld exactly ACK_LAT cycles later (test ACK_LAT=1 and 3). Then hw_pulse with 0xDEADBEEF -> read returns 0xDEADBEEF.
- HW_CLR reg2 (RST 0xFFFFFFFF), hw_next_value=0x0000FFFF for one cycle -> 0xFFFF0000. HW_SET reg3, mask 0xFFFFFFFF -> 0xFFFFFFFF.
- SW_RCLR reg read returns 0x000000F0, then value 0. Same cycle with HW_SET mask 0x1 -> final value 0x00000001.
- SW_W1C reg holding 0xFF, write 0x0F -> 0xF0. Out-of-range addr BASE+0x40 -> ack_vld with rd_data=0 and no register change.
- global_sync_reset_in pulsed while in WAIT (ACK_LAT=4) -> no ack_vld, all registers at RST_VAL, global_sync_reset_out high one cycle later; the next request completes normally.
